machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width; only 32 supported.
REQ-002 SHALL provide parameter PRESCALE, default 1, clocks per mtime tick when MTIMER_PRESCALER_EN is defined; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 i_req  input  1  bus access strobe; one access per asserted cycle.
REQ-006 i_we  input  1  1 = write, 0 = read.
REQ-007 i_addr  input  3  word offset into the register map.
REQ-008 i_wdata  input  32  write data.
REQ-009 o_rdata  output  32  read data, valid with o_ack.
REQ-010 o_ack  output  1  access-complete pulse.
REQ-011 o_timer_int  output  1  level interrupt to CSR i_timer_int.
REQ-012 o_software_int  output  1  level interrupt to CSR i_software_int.
REQ-013 o_mtime  output  64  current mtime value, for TIME/TIMEH CSR reads.

Function
REQ-014 Register map SHALL be: 0 MSIP (bit 0 only, upper bits read 0); 2 MTIMECMP_LO; 3 MTIMECMP_HI; 4 MTIME_LO; 5 MTIME_HI.
REQ-015 Offsets 1, 6 and 7 SHALL read 0, ignore writes and still ack.
REQ-016 Handshake: every cycle with i_req=1 is accepted; o_ack=1 exactly one cycle later; back-to-back accesses at full rate; no stalls.
REQ-017 o_rdata SHALL be registered, valid only when o_ack=1 for a read, and 0 otherwise (idle or write ack).
REQ-018 Reads SHALL return register values from the accept cycle, before that edge's updates.
REQ-019 mtime SHALL be 64-bit unsigned, incrementing by 1 per tick; 0xFFFF_FFFF_FFFF_FFFF wraps to 0, with no carry or flag.
REQ-020 A write to MTIME_LO/HI SHALL replace that half at the accept edge; the other half keeps its current value; the tick is suppressed that cycle (the write wins).
REQ-021 A MTIME_LO read SHALL snapshot mtime[63:32] into a shadow register; a MTIME_HI read SHALL return the shadow, not live mtime[63:32].
REQ-022 MTIMECMP halves SHALL be written independently at the accept edge; no side effects.
REQ-023 o_timer_int SHALL be registered: value after edge n = (mtime >= mtimecmp), unsigned 64-bit, using values held in the cycle before edge n.
REQ-024 o_timer_int SHALL remain high while the condition holds; it clears one cycle after mtimecmp is written above mtime, or after mtime wraps below mtimecmp.
REQ-025 o_software_int SHALL equal the MSIP bit 0 flop; it changes one cycle after the write is accepted.
REQ-026 Simultaneous MTIMECMP write and mtime reaching the compare value: the compare SHALL use old values; the new mtimecmp takes effect at the next edge.
REQ-027 o_mtime SHALL be the mtime register output directly, with no added latency.

Reset
REQ-028 With reset=0 at a rising edge, the block SHALL set: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, MSIP=0, shadow=0, prescale count=0, o_ack=0, o_rdata=0, o_timer_int=0.
REQ-029 Reset SHALL override every other event, including in-flight accesses; an access accepted the cycle before reset SHALL produce no ack.
REQ-030 mtime SHALL not tick in any cycle where reset=0.

Configuration
REQ-031 Macro MTIMER_PRESCALER_EN defined: a 16-bit prescale counter counts 0..PRESCALE-1; a tick occurs on the edge where count == PRESCALE-1, after which the count returns to 0.
REQ-032 With MTIMER_PRESCALER_EN defined, any write to MTIME_LO/HI SHALL also clear the prescale counter.
REQ-033 Macro MTIMER_PRESCALER_EN undefined: mtime ticks every cycle; PRESCALE is ignored; no prescale counter hardware exists.

Verification
REQ-034 Carry: write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE (no prescaler); read LO then HI 2+ cycles later -> HI=1 via shadow, LO equal to the elapsed tick count minus 2.
REQ-035 Compare: write MTIMECMP_HI=0, MTIMECMP_LO=0x20, then MTIME_LO=0x10 with MTIME_HI=0 -> o_timer_int rises 17 cycles after the MTIME_LO write edge; then write MTIMECMP_LO=0xFFFF_FFFF -> o_timer_int falls the next cycle.
REQ-036 MSIP: write 1 -> o_software_int=1 next cycle; write 0xFFFF_FFFE -> o_software_int=0; a read then returns 0.
REQ-037 Wrap: mtime=0xFFFF_FFFF_FFFF_FFFF with mtimecmp at its reset value -> o_timer_int=1; after the tick mtime=0 and o_timer_int=0 one cycle later.
REQ-038 Shadow: mtime=0x1_FFFF_FFF0; read LO, wait 32 cycles, read HI -> returns 1 while o_mtime[63:32]=2.
REQ-039 Prescaler: MTIMER_PRESCALER_EN, PRESCALE=4 -> mtime advances once per 4 cycles; an MTIME write restarts the 4-cycle phase; reset asserted mid-access -> no o_ack.

Source files
------------

// File: rtl/machine_timer.sv
// Machine-mode timer (mtime/mtimecmp/msip) with a fixed one-cycle bus ack; no backpressure.
// Latency: reads/writes ack one cycle after i_req. Define MTIMER_PRESCALER_EN to tick every PRESCALE clocks.
module machine_timer #(
    parameter int XLEN     = 32,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [2:0]      i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_ack,
    output logic            o_timer_int,
    output logic            o_software_int,
    output logic [63:0]     o_mtime
);
    localparam logic [2:0] A_MSIP   = 3'd0;
    localparam logic [2:0] A_CMP_LO = 3'd2;
    localparam logic [2:0] A_CMP_HI = 3'd3;
    localparam logic [2:0] A_MT_LO  = 3'd4;
    localparam logic [2:0] A_MT_HI  = 3'd5;

    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            msip_q, msip_d;
    logic            ack_q, ack_d;
    logic            tint_q, tint_d;
    logic            tick;
    logic            wr;
    logic            rd;
    logic            mtime_wr;

    assign wr       = i_req & i_we;
    assign rd       = i_req & ~i_we;
    assign mtime_wr = wr & ((i_addr == A_MT_LO) | (i_addr == A_MT_HI));

`ifdef MTIMER_PRESCALER_EN
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;

    assign tick = (presc_q == PRESC_LAST);

    // An mtime write restarts the prescale phase so software sees a full period.
    always_comb begin
        presc_d = presc_q + 16'd1;
        if (tick || mtime_wr) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        shadow_d   = shadow_q;
        rdata_d    = '0;
        ack_d      = i_req;
        tint_d     = (mtime_q >= mtimecmp_q);

        if (wr) begin
            case (i_addr)
                A_MSIP:   msip_d            = i_wdata[0];
                A_CMP_LO: mtimecmp_d[31:0]  = i_wdata;
                A_CMP_HI: mtimecmp_d[63:32] = i_wdata;
                A_MT_LO:  mtime_d           = {mtime_q[63:32], i_wdata};
                A_MT_HI:  mtime_d           = {i_wdata, mtime_q[31:0]};
                default:  ;
            endcase
        end

        // A LO read freezes the upper half so a following HI read is carry-consistent.
        if (rd) begin
            case (i_addr)
                A_MSIP:   rdata_d = {{(XLEN-1){1'b0}}, msip_q};
                A_CMP_LO: rdata_d = mtimecmp_q[31:0];
                A_CMP_HI: rdata_d = mtimecmp_q[63:32];
                A_MT_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                A_MT_HI:  rdata_d = shadow_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            tint_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            tint_q     <= tint_d;
        end
    end

    // An in-flight ack is dropped as soon as reset is seen, not just at the next edge.
    assign o_ack          = ack_q & reset;
    assign o_rdata        = reset ? rdata_q : '0;
    assign o_timer_int    = tint_q;
    assign o_software_int = msip_q;
    assign o_mtime        = mtime_q;

endmodule

// File: tb/tb_machine_timer.sv
// Randomized scoreboard bench for machine_timer against a behavioural register-map model.
module tb_machine_timer;
`ifdef MTIMER_PRESCALER_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_addr = 3'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic        o_timer_int;
    logic        o_software_int;
    logic [63:0] o_mtime;

    always #5 clk = ~clk;

    machine_timer #(.XLEN(32), .PRESCALE(PS)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_we          (i_we),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ack         (o_ack),
        .o_timer_int   (o_timer_int),
        .o_software_int(o_software_int),
        .o_mtime       (o_mtime)
    );

    // Reference state: values the DUT should hold after the upcoming edge.
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_cmp = '1;
    logic [31:0] m_shadow = 32'd0;
    logic        m_msip = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_tint = 1'b0;
    int          m_phase = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_e;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        logic [63:0] mt0;
        bit          tick;
        if (!reset) begin
            m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_msip = 1'b0;
            m_ack = 1'b0; m_tint = 1'b0; m_phase = 0;
            exp_q.delete();
            return;
        end
        mt0    = m_mtime;
        m_tint = (mt0 >= m_cmp);
        m_ack  = i_req;
        tick   = (m_phase == PS - 1);
        m_phase = tick ? 0 : m_phase + 1;
        if (i_req && !i_we) begin
            case (i_addr)
                3'd0: exp_q.push_back({31'd0, m_msip});
                3'd2: exp_q.push_back(m_cmp[31:0]);
                3'd3: exp_q.push_back(m_cmp[63:32]);
                3'd4: begin exp_q.push_back(mt0[31:0]); m_shadow = mt0[63:32]; end
                3'd5: exp_q.push_back(m_shadow);
                default: exp_q.push_back(32'd0);
            endcase
        end else if (i_req) begin
            exp_q.push_back(32'd0);
        end
        m_mtime = tick ? mt0 + 64'd1 : mt0;
        if (i_req && i_we) begin
            case (i_addr)
                3'd0: m_msip = i_wdata[0];
                3'd2: m_cmp[31:0] = i_wdata;
                3'd3: m_cmp[63:32] = i_wdata;
                3'd4: begin m_mtime = {mt0[63:32], i_wdata}; m_phase = 0; end
                3'd5: begin m_mtime = {i_wdata, mt0[31:0]}; m_phase = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic rn, input logic rq, input logic we,
                        input logic [2:0] ad, input logic [31:0] wd);
        @(negedge clk);
        #1;
        reset = rn; i_req = rq; i_we = we; i_addr = ad; i_wdata = wd;
        model_edge();
        chk_en = 1'b1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] wd);
        step(1'b1, 1'b1, 1'b1, ad, wd);
    endtask

    task automatic rd(input logic [2:0] ad);
        step(1'b1, 1'b1, 1'b0, ad, $urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 3'(k), $urandom);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every ack.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 64'(o_ack), 64'(m_ack));
            if (o_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 64'(o_ack), 64'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("rdata", 64'(o_rdata), 64'(exp_e));
                end
            end else begin
                check("rdata_idle", 64'(o_rdata), 64'd0);
            end
            check("mtime", o_mtime, m_mtime);
            check("timer_int", 64'(o_timer_int), 64'(m_tint));
            check("software_int", 64'(o_software_int), 64'(m_msip));
        end
    end

    initial begin
        // Reset, with an access presented while reset is held.
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd4, 32'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        idle(2);
        rd(3'd2); rd(3'd3); rd(3'd1); wr(3'd6, 32'hDEAD_BEEF); rd(3'd6); rd(3'd7);

        // MSIP set, clear with upper bits set, read back.
        wr(3'd0, 32'd1); idle(1);
        wr(3'd0, 32'hFFFF_FFFE); rd(3'd0); idle(1);

        // Carry through the shadow register.
        wr(3'd5, 32'd0); wr(3'd4, 32'hFFFF_FFFE); idle(3);
        rd(3'd4); idle(2); rd(3'd5); idle(1);

        // Compare match, then compare moved above mtime.
        wr(3'd3, 32'd0); wr(3'd2, 32'h20); wr(3'd5, 32'd0); wr(3'd4, 32'h10);
        idle(20 * PS);
        wr(3'd2, 32'hFFFF_FFFF); idle(2);

        // Wrap with mtimecmp at all ones.
        wr(3'd3, 32'hFFFF_FFFF); wr(3'd5, 32'hFFFF_FFFF); wr(3'd4, 32'hFFFF_FFFF);
        idle(3 * PS);

        // Shadow holds while the live upper half advances.
        wr(3'd5, 32'd1); wr(3'd4, 32'hFFFF_FFF0); rd(3'd4);
        idle(32); rd(3'd5); idle(1);

        // Reset landing on an access.
        rd(3'd4); step(1'b0, 1'b1, 1'b0, 3'd4, 32'd0); idle(2);
        wr(3'd2, 32'd40); wr(3'd3, 32'd0); idle(3);

        // Randomized traffic, small values favoured so compares actually hit.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
            if ($urandom_range(0, 63) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd);
            else
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd);
        end

        idle(3);
        @(negedge clk);
        #2;
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
